result_checker: RTL and testbench
=================================

Name: result_checker

Overview:
- Reader side of the result BRAM (ram_out port B).
- After the control logic has filled the BRAM with DUT outputs, this block sweeps every address once.
- Each word is compared against a golden-result ROM.
- It accumulates the word-error and bit-error counts and captures the first failing address, so a single overclocking run yields an error-rate figure without ChipScope post-processing.
- Runs entirely in the 200 MHz clk domain, alongside control.

Parameters:
- AddrWL, 11, address width of the result BRAM and golden ROM.
- data_width_out, 18, width of one result word.
- NUM_SAMPLES, 2**AddrWL, number of words checked per run. Legal range is 1..2**AddrWL.
- BITCNT_W, AddrWL+5, width of the bit-error accumulator. Must be at least AddrWL + clog2(data_width_out+1).

Ports:
- clk  in  1  200 MHz system clock.
- nrst  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  single-cycle pulse from control, issued when the BRAM write phase is complete.
- bram_read_en  out  1  enb of ram_out port B (rstb is driven as its inverse at top level).
- bram_address_read  out  AddrWL  addrb of ram_out.
- bram_dout  in  data_width_out  doutb of ram_out; 1-cycle read latency.
- gold_en  out  1  golden ROM enable; always equal to bram_read_en.
- gold_addr  out  AddrWL  golden ROM address; always equal to bram_address_read.
- gold_dout  in  data_width_out  golden ROM data; 1-cycle read latency.
- busy  out  1  high from the cycle after start until done rises.
- done  out  1  level; high when results are valid.
- word_err_count  out  AddrWL+1  number of mismatching words.
- bit_err_count  out  BITCNT_W  total differing bits.
- first_err_valid  out  1  at least one mismatch seen.
- first_err_addr  out  AddrWL  address of the first mismatch.

Behaviour:
- Reset values: every output and internal register is 0 and the FSM is in IDLE. Reset is asynchronous and takes effect mid-run; no partial results are kept.
- FSM: IDLE -> READ -> DRAIN -> DONE -> (start) READ.
- IDLE:
  - start=1 -> READ.
  - All counters, first_err_*, and the address are cleared in the same edge.
- READ, one address per cycle:
  - bram_read_en=1, address = rd_addr.
  - rd_addr increments from 0 to NUM_SAMPLES-1.
  - Issuing address NUM_SAMPLES-1 -> DRAIN. bram_read_en drops in the following cycle.
- Pipeline:
  - Stage 1: read-enable and address delayed 1 cycle, aligned with the data.
  - Stage 2: registered XOR of bram_dout and gold_dout, plus valid and address.
  - Stage 3: popcount of the XOR; accumulate word_err_count (+1 if XOR is nonzero) and bit_err_count.
  - The first nonzero XOR sets first_err_valid=1 and latches its address. Later mismatches do not overwrite it.
  - Latency from issuing address N to its contribution appearing in the counters: 3 cycles.
- DRAIN: waits until the pipeline valid bits are all 0, exactly 3 cycles, then -> DONE.
- DONE:
  - done=1, busy=0, results held stable.
  - start=1 -> READ, which clears the results, drops done, and raises busy on the next cycle.
- start received in READ or DRAIN is ignored, with no restart and no counter disturbance.
- Counters cannot overflow at legal parameter values: word count max 2**AddrWL fits AddrWL+1 bits. No wrap or saturation logic.
- NUM_SAMPLES=1: READ lasts exactly one cycle.
- busy and done are never high together.
- bram_read_en is high only in READ, for exactly NUM_SAMPLES consecutive cycles.

Decomposition:
- Shared package result_checker_pkg:
  - FSM state encoding (IDLE, READ, DRAIN, DONE, 2-bit).
  - PIPE_LAT=3.
  - clog2 constant function used for the BITCNT_W check.
- One sub-module, popcount (parameter W=data_width_out): combinational bit count, registered by the parent in stage 3.

Test Plan:
- Identical golden and result memories with all 2048 words random, start pulse:
  - bram_read_en high for exactly 2048 cycles.
  - done rises 3 cycles after the last address.
  - word_err_count=0, bit_err_count=0, first_err_valid=0.
- Result word at address 5 = golden XOR 18'h00003, address 1000 = golden XOR 18'h3FFFF:
  - word_err_count=2, bit_err_count=20.
  - first_err_valid=1, first_err_addr=5.
- Every result word bitwise inverted:
  - word_err_count=2048, bit_err_count=36864 (no overflow), first_err_addr=0.
- Second start pulse while in READ at address 300: ignored, final counts identical to an undisturbed run.
- nrst asserted asynchronously mid-READ, then start after release:
  - All outputs are 0 during reset.
  - The new run's counts match a clean run with no carry-over.
- NUM_SAMPLES=1, mismatch at address 0:
  - One-cycle read, done 4 cycles after start.
  - word_err_count=1, first_err_addr=0.
  - Then a start pulse in DONE clears done and re-runs with the same result.

Source files
------------

// File: rtl/result_checker_pkg.sv
// Shared types and constants for the result BRAM checker.
// Holds the sweep FSM encoding and the pipeline depth between address issue and accumulation.
package result_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int PIPE_LAT = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/result_checker_popcount.sv
// Combinational count of set bits in one XOR word.
// The parent registers the result as part of its accumulation stage.
module popcount
    import result_checker_pkg::*;
#(
    parameter int W = 18,
    localparam int POP_W = clog2(W + 1)
) (
    input  logic [W-1:0]     bits,
    output logic [POP_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + POP_W'(bits[i]);
        end
    end

endmodule

// File: rtl/result_checker.sv
// Sweeps the result BRAM once per start, compares each word with the golden ROM and
// accumulates word/bit error counts plus the first failing address.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | after reset, waiting for the first start
// ST_READ  | issuing one address per cycle, 0 .. NUM_SAMPLES-1
// ST_DRAIN | last address issued, waiting for the compare pipeline to empty
// ST_DONE  | results valid and held until the next start
module result_checker
    import result_checker_pkg::*;
#(
    parameter int AddrWL         = 11,
    parameter int data_width_out = 18,
    parameter int NUM_SAMPLES    = 2**AddrWL,
    parameter int BITCNT_W       = AddrWL + 5
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      start,
    output logic                      bram_read_en,
    output logic [AddrWL-1:0]         bram_address_read,
    input  logic [data_width_out-1:0] bram_dout,
    output logic                      gold_en,
    output logic [AddrWL-1:0]         gold_addr,
    input  logic [data_width_out-1:0] gold_dout,
    output logic                      busy,
    output logic                      done,
    output logic [AddrWL:0]           word_err_count,
    output logic [BITCNT_W-1:0]       bit_err_count,
    output logic                      first_err_valid,
    output logic [AddrWL-1:0]         first_err_addr
);

    localparam int POP_W = clog2(data_width_out + 1);
    localparam int WCNT_W = AddrWL + 1;
    localparam logic [AddrWL-1:0] LAST_ADDR = AddrWL'(NUM_SAMPLES - 1);

    if (BITCNT_W < AddrWL + POP_W) begin : g_bad_bitcnt_w
        $error("result_checker: BITCNT_W too narrow for the worst-case bit error total");
    end
    if (NUM_SAMPLES < 1 || NUM_SAMPLES > 2**AddrWL) begin : g_bad_num_samples
        $error("result_checker: NUM_SAMPLES outside 1..2**AddrWL");
    end

    state_t                    state;
    logic                      clear;
    logic                      v1, v2;
    logic [AddrWL-1:0]         a1, a2;
    logic [data_width_out-1:0] x2;
    logic [POP_W-1:0]          pop;

    // A start accepted from IDLE or DONE wipes the previous results on the same edge.
    assign clear     = start && (state == ST_IDLE || state == ST_DONE);
    assign gold_en   = bram_read_en;
    assign gold_addr = bram_address_read;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state             <= ST_IDLE;
            bram_read_en      <= 1'b0;
            bram_address_read <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state             <= ST_READ;
                        bram_read_en      <= 1'b1;
                        bram_address_read <= '0;
                        busy              <= 1'b1;
                        done              <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (bram_address_read == LAST_ADDR) begin
                        state        <= ST_DRAIN;
                        bram_read_en <= 1'b0;
                    end else begin
                        bram_address_read <= bram_address_read + AddrWL'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!v1 && !v2) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage 1 lines up with the memory read latency; stage 2 holds the registered XOR.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v1 <= 1'b0;
            a1 <= '0;
            v2 <= 1'b0;
            a2 <= '0;
            x2 <= '0;
        end else begin
            v1 <= bram_read_en;
            a1 <= bram_address_read;
            v2 <= v1;
            a2 <= a1;
            x2 <= v1 ? (bram_dout ^ gold_dout) : '0;
        end
    end

    popcount #(.W(data_width_out)) u_popcount (
        .bits  (x2),
        .count (pop)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            word_err_count  <= '0;
            bit_err_count   <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (clear) begin
            word_err_count  <= '0;
            bit_err_count   <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (v2 && (x2 != '0)) begin
            word_err_count <= word_err_count + WCNT_W'(1);
            bit_err_count  <= bit_err_count + BITCNT_W'(pop);
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_addr  <= a2;
            end
        end
    end

endmodule

// File: tb/tb_result_checker.sv
// Randomized bench for result_checker: memory models around a full-size and a
// single-sample instance, with expected results recomputed from the memory contents.
module tb_result_checker;

    localparam int AW = 11;
    localparam int DW = 18;
    localparam int NW = 2048;
    localparam int BW = AW + 5;

    logic          clk;
    logic          nrst;
    logic          start;
    logic          start_1;

    logic          bram_read_en, gold_en, busy, done, first_err_valid;
    logic [AW-1:0] bram_address_read, gold_addr, first_err_addr;
    logic [DW-1:0] bram_dout, gold_dout;
    logic [AW:0]   word_err_count;
    logic [BW-1:0] bit_err_count;

    logic          bram_read_en_1, gold_en_1, busy_1, done_1, first_err_valid_1;
    logic [AW-1:0] bram_address_read_1, gold_addr_1, first_err_addr_1;
    logic [DW-1:0] bram_dout_1, gold_dout_1;
    logic [AW:0]   word_err_count_1;
    logic [BW-1:0] bit_err_count_1;

    logic [DW-1:0] res_mem  [0:NW-1];
    logic [DW-1:0] gold_mem [0:NW-1];

    int n_checks = 0;
    int n_errors = 0;

    result_checker dut (
        .clk (clk), .nrst (nrst), .start (start),
        .bram_read_en (bram_read_en), .bram_address_read (bram_address_read),
        .bram_dout (bram_dout), .gold_en (gold_en), .gold_addr (gold_addr),
        .gold_dout (gold_dout), .busy (busy), .done (done),
        .word_err_count (word_err_count), .bit_err_count (bit_err_count),
        .first_err_valid (first_err_valid), .first_err_addr (first_err_addr)
    );

    result_checker #(.NUM_SAMPLES(1)) dut1 (
        .clk (clk), .nrst (nrst), .start (start_1),
        .bram_read_en (bram_read_en_1), .bram_address_read (bram_address_read_1),
        .bram_dout (bram_dout_1), .gold_en (gold_en_1), .gold_addr (gold_addr_1),
        .gold_dout (gold_dout_1), .busy (busy_1), .done (done_1),
        .word_err_count (word_err_count_1), .bit_err_count (bit_err_count_1),
        .first_err_valid (first_err_valid_1), .first_err_addr (first_err_addr_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories, one cycle of latency.
    always @(posedge clk) begin
        if (bram_read_en)   bram_dout   <= res_mem[bram_address_read];
        if (gold_en)        gold_dout   <= gold_mem[gold_addr];
        if (bram_read_en_1) bram_dout_1 <= res_mem[bram_address_read_1];
        if (gold_en_1)      gold_dout_1 <= gold_mem[gold_addr_1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outputs_or();
        return 32'(|{bram_read_en, bram_address_read, gold_en, gold_addr, busy, done,
                     word_err_count, bit_err_count, first_err_valid, first_err_addr});
    endfunction

    task automatic model(input int n, output int ew, output int eb, output int efv, output int efa);
        logic [DW-1:0] x;
        ew = 0; eb = 0; efv = 0; efa = 0;
        for (int i = 0; i < n; i++) begin
            x = res_mem[i] ^ gold_mem[i];
            if (x != '0) begin
                ew++;
                eb += $countones(x);
                if (efv == 0) begin
                    efv = 1;
                    efa = i;
                end
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NW; i++) begin
            gold_mem[i] = DW'($urandom);
            res_mem[i]  = gold_mem[i];
        end
    endtask

    task automatic sprinkle_errors(input int one_in);
        for (int i = 0; i < NW; i++) begin
            if ($urandom_range(one_in - 1) == 0)
                res_mem[i] = gold_mem[i] ^ (DW'($urandom) | DW'(1 << $urandom_range(DW - 1)));
        end
    endtask

    // Pulse start on the main instance and follow it until done; optionally re-pulse
    // start when a given address is on the read port.
    task automatic run_main(input int inject_at, output int rd_cyc, output int lat,
                            output int overlap, output logic busy_first, output logic timed_out);
        int k;
        logic injected;
        injected = 1'b0;
        rd_cyc = 0; overlap = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 1;
        busy_first = busy;
        while (!done && k < 5000) begin
            if (bram_read_en) rd_cyc++;
            if (busy && done) overlap++;
            if (inject_at >= 0 && !injected && bram_read_en &&
                int'(bram_address_read) == inject_at) begin
                start = 1'b1;
                injected = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        timed_out = !done;
        lat = k - 1;
    endtask

    task automatic check_main(input string pfx);
        int ew, eb, efv, efa;
        model(NW, ew, eb, efv, efa);
        check({pfx, "_word"}, 32'(word_err_count), 32'(ew));
        check({pfx, "_bits"}, 32'(bit_err_count), 32'(eb));
        check({pfx, "_fvalid"}, 32'(first_err_valid), 32'(efv));
        check({pfx, "_faddr"}, 32'(first_err_addr), 32'(efa));
    endtask

    task automatic run_and_check(input string pfx, input int inject_at);
        int rd_cyc, lat, overlap;
        logic busy_first, timed_out;
        run_main(inject_at, rd_cyc, lat, overlap, busy_first, timed_out);
        check({pfx, "_timeout"}, 32'(timed_out), 32'd0);
        check({pfx, "_rd_cycles"}, 32'(rd_cyc), 32'(NW));
        check({pfx, "_done_lat"}, 32'(lat), 32'(NW + 3));
        check({pfx, "_busy_after_start"}, 32'(busy_first), 32'd1);
        check({pfx, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        check_main(pfx);
    endtask

    task automatic run_small(input string pfx, input int exp_bits);
        int k, rd_cyc;
        rd_cyc = 0;
        @(negedge clk) start_1 = 1'b1;
        @(negedge clk) start_1 = 1'b0;
        k = 1;
        check({pfx, "_busy_after_start"}, 32'(busy_1), 32'd1);
        check({pfx, "_done_cleared"}, 32'(done_1), 32'd0);
        check({pfx, "_word_cleared"}, 32'(word_err_count_1), 32'd0);
        while (!done_1 && k < 100) begin
            if (bram_read_en_1) begin
                rd_cyc++;
                check({pfx, "_addr"}, 32'(bram_address_read_1), 32'd0);
            end
            @(negedge clk);
            k++;
        end
        check({pfx, "_timeout"}, 32'(!done_1), 32'd0);
        check({pfx, "_rd_cycles"}, 32'(rd_cyc), 32'd1);
        check({pfx, "_done_lat"}, 32'(k - 1), 32'd4);
        check({pfx, "_word"}, 32'(word_err_count_1), 32'd1);
        check({pfx, "_bits"}, 32'(bit_err_count_1), 32'(exp_bits));
        check({pfx, "_fvalid"}, 32'(first_err_valid_1), 32'd1);
        check({pfx, "_faddr"}, 32'(first_err_addr_1), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] mask0;
        nrst = 1'b0; start = 1'b0; start_1 = 1'b0;
        bram_dout = '0; gold_dout = '0; bram_dout_1 = '0; gold_dout_1 = '0;
        fill_random();
        repeat (3) @(negedge clk);
        check("reset_outputs", outputs_or(), 32'd0);
        check("reset_done_1", 32'(done_1), 32'd0);
        @(negedge clk) nrst = 1'b1;

        // identical memories
        run_and_check("clean", -1);
        check("clean_word_const", 32'(word_err_count), 32'd0);

        // two targeted mismatches
        fill_random();
        res_mem[5]    = gold_mem[5] ^ 18'h00003;
        res_mem[1000] = gold_mem[1000] ^ 18'h3FFFF;
        run_and_check("two_err", -1);
        check("two_err_word_const", 32'(word_err_count), 32'd2);
        check("two_err_bits_const", 32'(bit_err_count), 32'd20);
        check("two_err_faddr_const", 32'(first_err_addr), 32'd5);

        // every word inverted
        for (int i = 0; i < NW; i++) res_mem[i] = ~gold_mem[i];
        run_and_check("all_inv", -1);
        check("all_inv_word_const", 32'(word_err_count), 32'd2048);
        check("all_inv_bits_const", 32'(bit_err_count), 32'd36864);

        // sparse random errors, then the same data with a stray start mid-READ
        fill_random();
        sprinkle_errors(16);
        run_and_check("sparse", -1);
        run_and_check("restart_ignored", 300);

        // asynchronous reset in the middle of a sweep
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_read_busy", 32'(busy), 32'd1);
        check("mid_read_count_nonzero", 32'(word_err_count != '0), 32'd1);
        #2 nrst = 1'b0;
        #1 check("async_reset_outputs", outputs_or(), 32'd0);
        @(negedge clk);
        check("reset_hold_outputs", outputs_or(), 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        check("after_reset_idle", outputs_or(), 32'd0);
        fill_random();
        sprinkle_errors(8);
        run_and_check("post_reset", -1);

        // single-sample instance with a mismatch at address 0
        mask0 = DW'($urandom) | 18'h00100;
        res_mem[0] = gold_mem[0] ^ mask0;
        run_small("single", $countones(mask0));
        check("single_done_held", 32'(done_1), 32'd1);
        run_small("single_rerun", $countones(mask0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
